// File: rtl/uart_pkg.sv
// Shared types and constants for the exp7 UART transmit path.
// Holds the arbiter state encoding and default character/timeout sizes.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LAUNCH    = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } state_e;

  localparam int UART_DATA_W        = 7;
  localparam int UART_START_TIMEOUT = 16;
  localparam int UART_IDX_W         = 3;

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin find-first-set: first set request at or above the
// pointer, wrapping past the top requester back to zero.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [UART_IDX_W-1:0] ptr_i,
  output logic [UART_IDX_W-1:0] idx_o,
  output logic                  valid_o
);

  localparam int SW = UART_IDX_W + 1;

  logic [2*NUM_REQ-1:0] dbl_sh;
  logic [NUM_REQ-1:0]   rot;
  logic [SW-1:0]        sum;
  logic [SW-1:0]        wrapped;

  // Rotate so bit 0 is the pointer position.
  assign dbl_sh = {req_i, req_i} >> ptr_i;
  assign rot    = dbl_sh[NUM_REQ-1:0];

  always_comb begin
    valid_o = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + SW'(k);
      end
    end
  end

  assign wrapped = (sum >= SW'(NUM_REQ))
                 ? sum - SW'(NUM_REQ)
                 : sum;
  assign idx_o   = wrapped[UART_IDX_W-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with
// round-robin grants, launch pulse, busy tracking and start timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int START_TIMEOUT = UART_START_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      enable,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [2:0]                owner,
  output logic                      busy_o,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  state_e                state_q;
  logic [UART_IDX_W-1:0] ptr_q;
  logic [UART_IDX_W-1:0] ptr_d;
  logic [UART_IDX_W-1:0] owner_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [NUM_REQ-1:0]    done_q;
  logic                  start_q;
  logic [DATA_W-1:0]     data_q;
  logic                  err_q;

  logic [UART_IDX_W-1:0] pick_idx;
  logic                  pick_vld;
  logic [DATA_W-1:0]     pick_data;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign ptr_d = (pick_idx == UART_IDX_W'(NUM_REQ - 1))
               ? '0
               : pick_idx + UART_IDX_W'(1);

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == UART_IDX_W'(i)) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && pick_vld) begin
            ack_q   <= NUM_REQ'(1) << pick_idx;
            data_q  <= pick_data;
            owner_q <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            // Transmitter never answered: drop the frame, no done.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done_q  <= NUM_REQ'(1) << owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign owner       = owner_q;
  assign busy_o      = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus
// random requests checked against a round-robin reference model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        resetN;
  logic [3:0]  req;
  logic [27:0] req_data;
  logic        enable;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        tx_start;
  logic [6:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  owner;
  logic        busy_o;
  logic        err_timeout;

  int nvec = 0;
  int nerr = 0;
  int ptr_m = 0;
  logic err_m = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .DATA_W        (7),
    .START_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .req         (req),
    .req_data    (req_data),
    .enable      (enable),
    .ack         (ack),
    .done        (done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .owner       (owner),
    .busy_o      (busy_o),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requesting index scanning upward from ptr_m.
  function automatic int pick(input logic [3:0] rq);
    for (int k = 0; k < 4; k++) begin
      if (rq[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk_reset_outs();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_owner", 32'(owner), 0);
  endtask

  // Full frame: grant, launch, busy after dly cycles for len cycles.
  task automatic serve(input logic [3:0] rq, input logic [27:0] d,
                       input int dly, input int len);
    int w;
    logic [6:0] ch;
    w  = pick(rq);
    ch = d[w*7 +: 7];
    req      = rq;
    req_data = d;
    enable   = 1'b1;
    @(negedge clk);
    chk("ack", 32'(ack), 32'(1 << w));
    chk("owner", 32'(owner), 32'(w));
    chk("busy_grant", 32'(busy_o), 1);
    req = rq & ~4'(1 << w);
    @(negedge clk);
    chk("tx_start", 32'(tx_start), 1);
    chk("tx_data", 32'(tx_data), 32'(ch));
    chk("ack_clear", 32'(ack), 0);
    ptr_m = (w + 1) % 4;
    repeat (dly) begin
      @(negedge clk);
      chk("start_once", 32'(tx_start), 0);
    end
    tx_busy = 1'b1;
    repeat (len) begin
      @(negedge clk);
      chk("no_early_done", 32'(done), 0);
      chk("owner_hold", 32'(owner), 32'(w));
      chk("data_hold", 32'(tx_data), 32'(ch));
    end
    tx_busy = 1'b0;
    req     = '0;
    @(negedge clk);
    chk("done", 32'(done), 32'(1 << w));
    chk("idle_after", 32'(busy_o), 0);
    chk("err_level", 32'(err_timeout), 32'(err_m));
  endtask

  initial begin
    logic [27:0] d;
    int w;
    resetN   = 1'b0;
    req      = '0;
    req_data = '0;
    enable   = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    resetN = 1'b1;
    @(negedge clk);

    // Contention from pointer 0: expect 0,1,3,0,1,3.
    for (int n = 0; n < 6; n++) begin
      serve(4'b1011, 28'($urandom), 1, 3);
    end

    // Single request on slot 2 carrying 'A'.
    d = 28'($urandom);
    d[14 +: 7] = 7'h41;
    serve(4'b0100, d, 2, 10);

    // Pointer now 3: wrap to 0, then pointer 1 picks slot 1.
    serve(4'b0001, 28'($urandom), 0, 2);
    serve(4'b0011, 28'($urandom), 0, 2);

    // Start timeout: busy never rises.
    w = pick(4'b1000);
    req = 4'b1000;
    enable = 1'b1;
    @(negedge clk);
    chk("to_ack", 32'(ack), 32'(1 << w));
    req = '0;
    @(negedge clk);
    chk("to_start", 32'(tx_start), 1);
    ptr_m = (w + 1) % 4;
    repeat (15) begin
      @(negedge clk);
      chk("to_err_early", 32'(err_timeout), 0);
      chk("to_done", 32'(done), 0);
    end
    @(negedge clk);
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_idle", 32'(busy_o), 0);
    chk("to_no_done", 32'(done), 0);
    err_m = 1'b1;
    serve(4'b0100, 28'($urandom), 3, 4);

    // Grants blocked while enable is low.
    enable = 1'b0;
    req = 4'b0001;
    repeat (20) begin
      @(negedge clk);
      chk("en_no_ack", 32'(ack), 0);
      chk("en_idle", 32'(busy_o), 0);
    end
    serve(4'b0001, 28'($urandom), 1, 2);

    // Random requests against the model.
    for (int n = 0; n < 12; n++) begin
      logic [3:0] rq;
      rq = 4'($urandom_range(1, 15));
      serve(rq, 28'($urandom), $urandom_range(0, 5),
            $urandom_range(1, 8));
    end

    // Reset in WAIT_DONE abandons the frame.
    w = pick(4'b0100);
    req = 4'b0100;
    enable = 1'b1;
    @(negedge clk);
    chk("mr_ack", 32'(ack), 32'(1 << w));
    req = '0;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    resetN = 1'b1;
    ptr_m = 0;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_done", 32'(done), 0);
    end
    serve(4'b1111, 28'($urandom), 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
